// File: rtl/store_align_buffer.sv
// Store alignment buffer: encodes sb/sh/sw into word address, replicated data and byte
// enables, queues them and issues over req/ack with a head timeout. Optional: STORE_ADES_EN.
module store_align_buffer #(
  parameter int DEPTH    = 2,
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [2:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        bus_err,
  output logic        exc_ades,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam bit WAIT_EN = (WAIT_MAX > 0);
  localparam logic [WW-1:0] WAIT_LAST = WAIT_EN ? WW'(WAIT_MAX - 1) : '0;

  logic [29:0]   r_addr_q  [DEPTH];
  logic [31:0]   r_wdata_q [DEPTH];
  logic [3:0]    r_be_q    [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [WW-1:0] r_wait;
  logic          r_bus_err;

  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_push;
  logic          w_pop;
  logic          w_tmo;
  logic          w_deq;

  // Misaligned sh/sw fall out naturally here: the be pattern ignores the offending
  // address bits, and invalid types take the sw encoding.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = st_data;
    case (st_type)
      3'b000: begin
        w_be    = 4'b0001 << st_addr[1:0];
        w_wdata = {4{st_data[7:0]}};
      end
      3'b001: begin
        w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{st_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = st_data;
      end
    endcase
  end

  assign st_ready = (r_count < CW'(DEPTH));
  assign mem_req  = (r_count != '0);
  assign busy     = mem_req;
  assign bus_err  = r_bus_err;

`ifdef STORE_ADES_EN
  logic w_misalign;
  logic w_ades;
  logic r_ades;

  always_comb begin
    case (st_type)
      3'b000:  w_misalign = 1'b0;
      3'b001:  w_misalign = st_addr[0];
      3'b011:  w_misalign = |st_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_push   = st_valid & st_ready & ~w_misalign;
  assign w_ades   = st_valid & st_ready & w_misalign;
  assign exc_ades = r_ades;

  always_ff @(posedge clk) begin
    if (reset) r_ades <= 1'b0;
    else       r_ades <= w_ades;
  end
`else
  assign w_push   = st_valid & st_ready;
  assign exc_ades = 1'b0;
`endif

  assign w_pop = mem_req & mem_ack;
  // Expiry and ack in the same cycle is a normal pop.
  assign w_tmo = WAIT_EN & mem_req & ~mem_ack & (r_wait == WAIT_LAST);
  assign w_deq = w_pop | w_tmo;

  assign mem_addr  = {r_addr_q[r_rd_ptr], 2'b00};
  assign mem_wdata = r_wdata_q[r_rd_ptr];
  assign mem_be    = r_be_q[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_q[r_wr_ptr]  <= st_addr[31:2];
      r_wdata_q[r_wr_ptr] <= w_wdata;
      r_be_q[r_wr_ptr]    <= w_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_tmo;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_deq)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (!mem_req || w_deq) r_wait <= '0;
      else if (WAIT_EN)      r_wait <= r_wait + WW'(1);
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// Scoreboard bench for store_align_buffer: directed warm-up then randomized stores,
// acks and resets, checked each cycle against a queue-based reference model.
module tb_store_align_buffer;

  localparam int DEPTH    = 2;
  localparam int WAIT_MAX = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  be;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic [2:0]  st_type = 3'b000;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        bus_err;
  logic        exc_ades;
  logic        busy;

  store_align_buffer #(.DEPTH(DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_type(st_type),
    .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .bus_err(bus_err),
    .exc_ades(exc_ades), .busy(busy)
  );

  always #5 clk = ~clk;

  ent_t m_q[$];
  ent_t pend_ent;
  bit   pend_valid = 0;
  bit   pend_exc = 0;
  bit   exp_bus_err = 0;
  bit   exp_exc = 0;
  int   m_wait = 0;
  bit   mon_en = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
  endtask

  // Reference encoding from the store rules, using arithmetic replication.
  function automatic void enc(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                              output bit legal, output ent_t e);
    e.a = a & 32'hFFFF_FFFC;
    if (t == 3'd0) begin
      legal = 1;
      e.be  = 4'(1 << (a % 4));
      e.w   = {24'd0, d[7:0]} * 32'h0101_0101;
    end else if (t == 3'd1) begin
      legal = (a % 2 == 0);
      e.be  = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
      e.w   = {16'd0, d[15:0]} * 32'h0001_0001;
    end else if (t == 3'd3) begin
      legal = (a % 4 == 0);
      e.be  = 4'b1111;
      e.w   = d;
    end else begin
      legal = 0;
      e.be  = 4'b1111;
      e.w   = d;
    end
  endfunction

  // Drives one cycle of stimulus and records what the model expects to be queued.
  task automatic drive(input bit v, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input bit ack, input bit rst);
    bit   legal;
    ent_t e;
    @(posedge clk);
    #1;
    reset = rst; st_valid = v; st_type = t; st_addr = a; st_data = d; mem_ack = ack;
    pend_valid = 0;
    pend_exc = 0;
    if (!rst && v && (m_q.size() < DEPTH)) begin
      enc(t, a, d, legal, e);
`ifdef STORE_ADES_EN
      if (legal) begin pend_valid = 1; pend_ent = e; end
      else pend_exc = 1;
`else
      pend_valid = 1;
      pend_ent = e;
`endif
    end
  endtask

  // Monitor: compare outputs with the model, then advance the model past the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("st_ready", 32'(st_ready), 32'(m_q.size() < DEPTH));
      check("mem_req", 32'(mem_req), 32'(m_q.size() != 0));
      check("busy", 32'(busy), 32'(m_q.size() != 0));
      check("bus_err", 32'(bus_err), 32'(exp_bus_err));
      check("exc_ades", 32'(exc_ades), 32'(exp_exc));
      if (m_q.size() != 0) begin
        check("mem_addr", mem_addr, m_q[0].a);
        check("mem_wdata", mem_wdata, m_q[0].w);
        check("mem_be", 32'(mem_be), 32'(m_q[0].be));
      end
      if (reset) begin
        m_q.delete();
        m_wait = 0;
        exp_bus_err = 0;
        exp_exc = 0;
      end else begin
        exp_bus_err = 0;
        exp_exc = pend_exc;
        if (m_q.size() != 0) begin
          if (mem_ack) begin
            void'(m_q.pop_front());
            m_wait = 0;
          end else begin
            m_wait++;
            if (WAIT_MAX > 0 && m_wait == WAIT_MAX) begin
              void'(m_q.pop_front());
              exp_bus_err = 1;
              m_wait = 0;
            end
          end
        end
        if (pend_valid) m_q.push_back(pend_ent);
      end
    end
  end

  logic [2:0] bad_types [5] = '{3'd2, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    int ack_pct;
    int r;
    logic [2:0] t;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    mon_en = 1;

    drive(1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 1, 0);
    drive(0, 3'b000, 0, 0, 1, 0);
    drive(0, 3'b000, 0, 0, 1, 0);
    drive(1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 0, 0);
    drive(1, 3'b011, 32'h0000_2004, 32'hDEAD_0001, 0, 0);
    drive(1, 3'b011, 32'h0000_2008, 32'h5555_AAAA, 0, 0);
    drive(0, 3'b000, 0, 0, 1, 0);
    drive(0, 3'b000, 0, 0, 0, 0);
    drive(0, 3'b000, 0, 0, 1, 0);
    drive(1, 3'b000, 32'h0000_4001, 32'h0000_0077, 0, 0);
    repeat (6) drive(0, 3'b000, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      drive(1, 3'(i % 2), 32'h0000_5000 + 32'(i * 6), 32'h1111_0000 + 32'(i), 1, 0);
    drive(0, 3'b000, 0, 0, 1, 0);
    drive(1, 3'b011, 32'h0000_3001, 32'hCAFE_F00D, 1, 0);
    drive(0, 3'b000, 0, 0, 1, 0);
    drive(1, 3'b001, 32'h0000_6002, 32'h0000_1234, 0, 0);
    drive(1, 3'b011, 32'h0000_6004, 32'h8765_4321, 0, 0);
    drive(0, 3'b000, 0, 0, 1, 1);
    drive(0, 3'b000, 0, 0, 1, 0);
    drive(0, 3'b000, 0, 0, 0, 0);

    for (int phase = 0; phase < 3; phase++) begin
      ack_pct = (phase == 0) ? 100 : (phase == 1) ? 60 : 10;
      for (int c = 0; c < 500; c++) begin
        r = $urandom_range(0, 9);
        if (r < 3)      t = 3'b000;
        else if (r < 6) t = 3'b001;
        else if (r < 9) t = 3'b011;
        else            t = bad_types[$urandom_range(0, 4)];
        drive($urandom_range(0, 99) < 60, t, $urandom, $urandom,
              $urandom_range(0, 99) < ack_pct, $urandom_range(0, 199) == 0);
      end
    end

    drive(0, 3'b000, 0, 0, 1, 0);
    drive(0, 3'b000, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/store_align_buffer.md
Name: store_align_buffer

Overview:
- Store-side counterpart of the load extender on the data-memory path.
- Takes sb/sh/sw requests from the MEM stage and generates the word-aligned address, the replicated write data and the byte enables.
- Queues them in a small FIFO and issues them to the data memory / bridge over a req/ack handshake.
- Stalls the pipeline through st_ready when the FIFO is full and drops requests whose ack never arrives.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- WAIT_MAX, 15, cycles a head entry waits for mem_ack before it is dropped; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- st_valid  input  1  store request valid.
- st_type  input  3  store type: 000 = sb, 001 = sh, 011 = sw; any other code is invalid.
- st_addr  input  32  byte address.
- st_data  input  32  register data (low byte / half / word used).
- st_ready  output  1  request accepted this cycle when high together with st_valid.
- mem_req  output  1  head entry presented to memory.
- mem_addr  output  32  word address of the head entry, bits [1:0] = 00.
- mem_wdata  output  32  aligned write data of the head entry.
- mem_be  output  4  byte enables of the head entry; bit i covers byte lane [8i+7:8i].
- mem_ack  input  1  memory completed the head write.
- bus_err  output  1  one-cycle pulse: head entry timed out and was dropped.
- exc_ades  output  1  one-cycle pulse: address-error store rejected (see Optional Feature).
- busy  output  1  FIFO non-empty.

Behaviour:
- Reset, synchronous: FIFO count = 0, read/write pointers = 0, wait counter = 0.
  - mem_req = 0, bus_err = 0, exc_ades = 0, busy = 0.
  - st_ready = 1 from the first cycle after reset.
- Reset mid-transfer flushes all entries; a pending ack in the reset cycle is ignored.
- Encoding (combinational from inputs, captured into the FIFO at push):
  - sb: be = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - sh: addr[1] = 0 gives be 0011; addr[1] = 1 gives be 1100; wdata = {2{data[15:0]}}.
  - sw: be = 1111; wdata = data.
  - mem_addr = {addr[31:2], 2'b00}.
- Misaligned: sh with addr[0] = 1; sw with addr[1:0] != 00; any invalid st_type.
- st_ready = (count < DEPTH); combinational from registered count only, with no dependence on mem_ack. A full FIFO stays unready even in a cycle where the head is acked.
- Push: st_valid & st_ready & legal request. The entry is written at the clock edge; count increments.
- Head visibility:
  - mem_req = (count != 0); mem_* are driven from the head entry register.
  - Earliest mem_req for a store pushed into an empty FIFO is the next cycle (1-cycle latency).
- Pop: mem_req & mem_ack. The head is removed at the edge and the next entry is presented the following cycle.
  - mem_addr/wdata/be stay stable while mem_req is high and no ack or timeout has occurred.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Timeout, WAIT_MAX > 0:
  - The wait counter increments each cycle mem_req = 1 and mem_ack = 0.
  - It clears on pop, on timeout, or when the FIFO is empty.
  - When the counter equals WAIT_MAX - 1 and mem_ack = 0, the head is dropped at that edge and bus_err pulses high in the following cycle.
  - An ack in the same cycle as expiry counts as a normal pop; no bus_err.
- mem_ack while mem_req = 0 is ignored.
- busy = (count != 0).

Optional Feature:
- Macro: STORE_ADES_EN.
- Defined:
  - A misaligned or invalid-type request with st_valid & st_ready is not pushed.
  - exc_ades pulses high for one cycle in the cycle after the request.
  - Nothing reaches memory.
- Undefined:
  - exc_ades is tied to 0.
  - A misaligned sh/sw is forced aligned: sh uses addr[1] with addr[0] ignored; sw ignores addr[1:0].
  - An invalid type is treated as sw.

Test Plan:
- Reset, then sb addr 0x0000_1003 data 0x0000_00A5, mem_ack tied 1 -> next cycle mem_req = 1, mem_addr 0x0000_1000, mem_be 1000, mem_wdata 0xA5A5_A5A5; FIFO empty the cycle after.
- sh addr 0x2002 data 0x1234_BEEF, then sw addr 0x2004 data 0xDEAD_0001, mem_ack held 0 -> st_ready = 0 after two pushes; head be 1100 / wdata 0xBEEF_BEEF stays stable; ack once -> second entry be 1111 / wdata 0xDEAD_0001 appears.
- FIFO holding 1 entry; push and ack in the same cycle -> count stays 1, order preserved, pointers wrap correctly over 6 consecutive stores.
- WAIT_MAX = 4, mem_ack never asserted -> head dropped after 4 cycles of mem_req, bus_err pulses once, next entry presented.
- STORE_ADES_EN defined, sw addr 0x3001 -> exc_ades = 1 for one cycle, mem_req stays 0. Macro undefined -> same request writes mem_addr 0x3000, be 1111.
- Assert reset while mem_req = 1 with 2 entries queued -> next cycle mem_req = 0, busy = 0, st_ready = 1.
